// File: rtl/bitwise_logic_unit.sv
// Registered WIDTH-bit two-operand logic unit with valid/ready on both sides,
// an optional accumulator that can stand in for operand A, and result flags.

module bitwise_logic_unit #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // operand side
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [2:0]       in_op_i,
    input  logic             in_acc_i,
    input  logic             acc_clr_i,
    // result side
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_res_o,
    output logic             out_zero_o,
    output logic             out_ones_o,
    output logic             out_par_o,
    output logic [WIDTH-1:0] acc_q_o
);

    typedef enum logic [2:0] {
        OpAnd   = 3'd0,
        OpOr    = 3'd1,
        OpXor   = 3'd2,
        OpNand  = 3'd3,
        OpNor   = 3'd4,
        OpXnor  = 3'd5,
        OpAndn  = 3'd6,
        OpPassA = 3'd7
    } op_e;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_res_q, out_res_d;
    logic             out_zero_q, out_zero_d;
    logic             out_ones_q, out_ones_d;
    logic             out_par_q, out_par_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             accept;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] result;
    op_e              op;

    assign in_ready_o = ~out_valid_q | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;
    assign op         = op_e'(in_op_i);

    // A same-edge clear is applied before the accumulator is used as operand A.
    assign acc_eff = acc_clr_i ? ACC_INIT : acc_q;
    assign opnd_a  = in_acc_i ? acc_eff : in_a_i;

    always_comb begin
        result = '0;
        unique case (op)
            OpAnd:   result = opnd_a & in_b_i;
            OpOr:    result = opnd_a | in_b_i;
            OpXor:   result = opnd_a ^ in_b_i;
            OpNand:  result = ~(opnd_a & in_b_i);
            OpNor:   result = ~(opnd_a | in_b_i);
            OpXnor:  result = ~(opnd_a ^ in_b_i);
            OpAndn:  result = opnd_a & ~in_b_i;
            OpPassA: result = opnd_a;
            default: result = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_zero_d  = out_zero_q;
        out_ones_d  = out_ones_q;
        out_par_d   = out_par_q;
        acc_d       = acc_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_res_d   = result;
            out_zero_d  = (result == '0);
            out_ones_d  = (result == {WIDTH{1'b1}});
            out_par_d   = ^result;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (accept && in_acc_i) begin
            acc_d = result;
        end else if (acc_clr_i) begin
            acc_d = ACC_INIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_zero_q  <= 1'b1;
            out_ones_q  <= 1'b0;
            out_par_q   <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_zero_q  <= out_zero_d;
            out_ones_q  <= out_ones_d;
            out_par_q   <= out_par_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_res_o   = out_res_q;
    assign out_zero_o  = out_zero_q;
    assign out_ones_o  = out_ones_q;
    assign out_par_o   = out_par_q;
    assign acc_q_o     = acc_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit at WIDTH=4: directed scenarios followed by
// randomized traffic with random backpressure, clears and resets.

module tb_bitwise_logic_unit;

    localparam int unsigned W = 4;
    localparam logic [W-1:0] INIT = 4'b1111;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] in_a_i;
    logic [W-1:0] in_b_i;
    logic [2:0]   in_op_i;
    logic         in_acc_i;
    logic         acc_clr_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] out_res_o;
    logic         out_zero_o;
    logic         out_ones_o;
    logic         out_par_o;
    logic [W-1:0] acc_q_o;

    bitwise_logic_unit #(
        .WIDTH    (W),
        .ACC_INIT (INIT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_a_i      (in_a_i),
        .in_b_i      (in_b_i),
        .in_op_i     (in_op_i),
        .in_acc_i    (in_acc_i),
        .acc_clr_i   (acc_clr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_res_o   (out_res_o),
        .out_zero_o  (out_zero_o),
        .out_ones_o  (out_ones_o),
        .out_par_o   (out_par_o),
        .acc_q_o     (acc_q_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         ones;
        logic         par;
    } exp_t;

    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    logic         ov_m;
    logic [W-1:0] acc_m;

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return a;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model is advanced at the edge and pushes expected results.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic acc, input logic clr,
                        input logic ordy, input logic rst);
        logic         rdy;
        logic         accept;
        logic [W-1:0] opa;
        logic [W-1:0] res;
        logic [W-1:0] acc_n;
        logic         ov_n;
        exp_t         e;
        in_valid_i  = v;
        in_a_i      = a;
        in_b_i      = b;
        in_op_i     = op;
        in_acc_i    = acc;
        acc_clr_i   = clr;
        out_ready_i = ordy;
        rst_i       = rst;
        #1;
        rdy = !ov_m || ordy;
        check("in_ready", int'(in_ready_o), int'(rdy));
        accept = v && rdy;
        opa    = acc ? (clr ? INIT : acc_m) : a;
        res    = ref_op(op, opa, b);
        ov_n   = accept ? 1'b1 : (ordy ? 1'b0 : ov_m);
        acc_n  = (accept && acc) ? res : (clr ? INIT : acc_m);
        e.res  = res;
        e.zero = (res == 0);
        e.ones = (res == 4'hF);
        e.par  = ($countones(res) % 2) == 1;
        @(posedge clk_i);
        if (rst) begin
            ov_m  = 1'b0;
            acc_m = INIT;
            sb.delete();
        end else begin
            if (accept) sb.push_back(e);
            ov_m  = ov_n;
            acc_m = acc_n;
        end
        #1;
        check("acc_q", int'(acc_q_o), int'(acc_m));
        check("out_valid", int'(out_valid_o), int'(ov_m));
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_out_res", int'(out_res_o), 0);
        check("rst_out_zero", int'(out_zero_o), 1);
        check("rst_out_ones", int'(out_ones_o), 0);
        check("rst_out_par", int'(out_par_o), 0);
        check("rst_acc_q", int'(acc_q_o), int'(INIT));
        check("rst_in_ready", int'(in_ready_o), 1);
    endtask

    // Monitor: a result is consumed when valid and ready are both high at the next edge.
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_result", int'(out_res_o), -1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_res", int'(out_res_o), int'(e.res));
                check("out_zero", int'(out_zero_o), int'(e.zero));
                check("out_ones", int'(out_ones_o), int'(e.ones));
                check("out_par", int'(out_par_o), int'(e.par));
            end
        end
    end

    initial begin
        ov_m  = 1'b0;
        acc_m = INIT;
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_reset_state();

        // All eight ops streamed back to back.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b1100, 4'b1010, 3'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure: second beat must wait while the first result is held.
        step(1'b1, 4'b1100, 4'b1010, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1100, 4'b1010, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("held_res", int'(out_res_o), 8);
        step(1'b1, 4'b1100, 4'b1010, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1100, 4'b1010, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Accumulating AND fold from INIT.
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 4'h0, 4'b1110, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'h0, 4'b1011, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'h0, 4'b0111, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("fold_acc", int'(acc_q_o), 2);
        check("fold_par", int'(out_par_o), 1);
        // Clear concurrent with an accumulating OR: operand A is INIT.
        step(1'b1, 4'h0, 4'b0001, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        // Clear with a non-accumulating beat still reloads the accumulator.
        step(1'b1, 4'h0, 4'b0001, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'h5, 4'h3, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);

        // Flags on all-ones and all-zero results.
        step(1'b1, 4'hF, 4'hF, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'hF, 4'hF, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset while a result is stalled discards it.
        step(1'b1, 4'h0, 4'h6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h3, 4'h6, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_reset_state();

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 10) < 7, W'($urandom), W'($urandom), 3'($urandom),
                 ($urandom % 2) == 1, ($urandom % 10) == 0, ($urandom % 10) < 7,
                 ($urandom % 60) == 0);
        end

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
